// File: rtl/lc3_mio_buffered.sv
// LC-3 memory/IO unit: MAR/MDR, xFE00-xFFFF device page, handshaked access FSM, buffered keyboard/display.
// Memory access completes MEM_LAT+1 cycles after MIO_EN and device access after 1; a full display FIFO drops writes.
module lc3_mio_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module lc3_mio_buffered #(
  parameter int KB_DEPTH  = 4,
  parameter int DSP_DEPTH = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] DATABUS,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic        LD_MAR,
  input  logic        LD_MDR,
  input  logic        GateMDR,
  output logic [15:0] MDRbus_out,
  output logic        R,
  output logic        KB_INT,
  output logic        DS_INT,
  input  logic        LD_char,
  input  logic [7:0]  I_char,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] DDR,
  output logic        WR_DDR,
  input  logic        DDR_RDY
);
  localparam int LW = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, MWAIT, DONE} state_t;

  state_t        state;
  logic [15:0]   mar;
  logic [15:0]   mdr;
  logic [15:0]   rd_hold;
  logic [LW-1:0] lat_cnt;
  logic          r_q;
  logic          kb_ie;
  logic          kb_ovr;
  logic          dsp_ie;

  logic          dev_page;
  logic          dev_fire;
  logic          sel_kbsr;
  logic          sel_kbdr;
  logic          sel_dsr;
  logic          sel_ddr;
  logic [15:0]   kbsr;
  logic [15:0]   dsr;
  logic [15:0]   dev_rdata;

  logic          kb_pop;
  logic          kb_drop;
  logic [7:0]    kb_head;
  logic          kb_empty;
  logic          kb_full;
  logic          dsp_push;
  logic          dsp_pop;
  logic [15:0]   dsp_head;
  logic          dsp_empty;
  logic          dsp_full;

  assign dev_page = (mar[15:9] == 7'h7F);
  assign sel_kbsr = (mar == 16'hFE00);
  assign sel_kbdr = (mar == 16'hFE02);
  assign sel_dsr  = (mar == 16'hFE04);
  assign sel_ddr  = (mar == 16'hFE06);
  // Device side effects happen only on the IDLE->DONE edge, never while parked in DONE.
  assign dev_fire = (state == IDLE) & MIO_EN & dev_page;

  assign kbsr = {~kb_empty, kb_ie, kb_ovr, 13'b0};
  assign dsr  = {~dsp_full, dsp_ie, 14'b0};

  always_comb begin
    dev_rdata = 16'h0000;
    case (mar)
      16'hFE00: dev_rdata = kbsr;
      16'hFE02: dev_rdata = {8'h00, kb_head};
      16'hFE04: dev_rdata = dsr;
      default:  dev_rdata = 16'h0000;
    endcase
  end

  assign kb_pop   = dev_fire & ~R_W & sel_kbdr;
  assign kb_drop  = LD_char & kb_full & ~kb_pop;
  assign dsp_push = dev_fire & R_W & sel_ddr;
  assign dsp_pop  = WR_DDR & DDR_RDY;

  lc3_mio_fifo #(.WIDTH(8), .DEPTH(KB_DEPTH)) u_kb_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (LD_char),
    .pop   (kb_pop),
    .din   (I_char),
    .head  (kb_head),
    .empty (kb_empty),
    .full  (kb_full)
  );

  lc3_mio_fifo #(.WIDTH(16), .DEPTH(DSP_DEPTH)) u_dsp_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dsp_push),
    .pop   (dsp_pop),
    .din   (mdr),
    .head  (dsp_head),
    .empty (dsp_empty),
    .full  (dsp_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      r_q     <= 1'b0;
      lat_cnt <= '0;
      rd_hold <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (MIO_EN) begin
            if (dev_page) begin
              state   <= DONE;
              r_q     <= 1'b1;
              rd_hold <= dev_rdata;
            end else begin
              state   <= MWAIT;
              lat_cnt <= LW'(1);
            end
          end
        end
        MWAIT: begin
          if (!MIO_EN) begin
            state <= IDLE;
          end else if (lat_cnt == LW'(MEM_LAT)) begin
            state   <= DONE;
            r_q     <= 1'b1;
            rd_hold <= mem_rdata;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        DONE: begin
          if (!MIO_EN) begin
            state <= IDLE;
            r_q   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          r_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mar <= 16'h0000;
      mdr <= 16'h0000;
    end else begin
      if (LD_MAR) mar <= DATABUS;
      if (LD_MDR & ~MIO_EN)
        mdr <= DATABUS;
      else if (LD_MDR & MIO_EN & r_q & ~R_W)
        mdr <= rd_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kb_ie  <= 1'b0;
      kb_ovr <= 1'b0;
      dsp_ie <= 1'b0;
    end else begin
      if (dev_fire & R_W & sel_kbsr) begin
        kb_ie  <= mdr[14];
        kb_ovr <= 1'b0;
      end
      // A dropped char in the same cycle as a KBSR write still counts as an overrun.
      if (kb_drop) kb_ovr <= 1'b1;
      if (dev_fire & R_W & sel_dsr) dsp_ie <= mdr[14];
    end
  end

  assign R          = r_q;
  assign MDRbus_out = GateMDR ? mdr : 16'bz;
  assign mem_addr   = mar;
  assign mem_wdata  = mdr;
  assign mem_en     = (state == IDLE) & MIO_EN & ~dev_page;
  assign mem_we     = R_W & mem_en;
  assign DDR        = dsp_head;
  assign WR_DDR     = ~dsp_empty;
  assign KB_INT     = kbsr[15] & kbsr[14];
  assign DS_INT     = dsr[15] & dsr[14];
endmodule

// File: tb/tb_lc3_mio_buffered.sv
// Bench for lc3_mio_buffered: vector table, hand-written corner sequences, then random ops against a queue model.
module tb_lc3_mio_buffered;
  localparam int KB_DEPTH  = 4;
  localparam int DSP_DEPTH = 4;
  localparam int MEM_LAT   = 2;
  localparam logic [1:0] OP_CHAR = 2'd0, OP_RD = 2'd1, OP_WR = 2'd2, OP_INT = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] DATABUS = 16'h0;
  logic        MIO_EN = 1'b0, R_W = 1'b0, LD_MAR = 1'b0, LD_MDR = 1'b0, GateMDR = 1'b0;
  logic        LD_char = 1'b0;
  logic [7:0]  I_char = 8'h0;
  logic        DDR_RDY = 1'b0;
  wire  [15:0] MDRbus_out;
  logic        R, KB_INT, DS_INT, mem_en, mem_we, WR_DDR;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, DDR;

  int errors = 0;
  int checks = 0;

  vec_t vt [40];
  int   nv = 0;

  logic [15:0] ref_mem [256];
  logic [7:0]  kb_q [$];
  logic [15:0] dsp_q [$];
  logic        kb_ie_m = 1'b0, kb_ovr_m = 1'b0, dsp_ie_m = 1'b0;
  logic        mon_en = 1'b0;
  logic [15:0] exp_ddr;

  logic [15:0] ram [256];
  logic [15:0] pipe_d [MEM_LAT];
  logic        pipe_v [MEM_LAT];

  lc3_mio_buffered #(.KB_DEPTH(KB_DEPTH), .DSP_DEPTH(DSP_DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .DATABUS(DATABUS), .MIO_EN(MIO_EN), .R_W(R_W),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .GateMDR(GateMDR), .MDRbus_out(MDRbus_out),
    .R(R), .KB_INT(KB_INT), .DS_INT(DS_INT), .LD_char(LD_char), .I_char(I_char),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .DDR(DDR), .WR_DDR(WR_DDR), .DDR_RDY(DDR_RDY)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(int i);
    return (i == 0) ? 16'h1234 : (16'h3000 ^ (16'(i) * 16'h0101));
  endfunction

  // External memory: fixed-latency read pipe, contents restored on reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
      for (int i = 0; i < MEM_LAT; i++) pipe_v[i] <= 1'b0;
    end else begin
      if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      pipe_v[0] <= mem_en && !mem_we;
      pipe_d[0] <= ram[mem_addr[7:0]];
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign mem_rdata = pipe_v[MEM_LAT-1] ? pipe_d[MEM_LAT-1] : 16'hBAD0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {15'b0, act}, {15'b0, exp});
  endtask

  // Display consumer: every accepted beat must match the model queue head.
  always @(negedge clk) begin
    if (mon_en && !reset && WR_DDR && DDR_RDY) begin
      if (dsp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ddr beat: got %h expected no data", DDR);
      end else begin
        exp_ddr = dsp_q.pop_front();
        chk("ddr beat", DDR, exp_ddr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    kb_q.delete();
    dsp_q.delete();
    kb_ie_m = 1'b0;
    kb_ovr_m = 1'b0;
    dsp_ie_m = 1'b0;
  endtask

  task automatic load_mar(input logic [15:0] a);
    DATABUS = a; LD_MAR = 1'b1; tick(); LD_MAR = 1'b0;
  endtask

  task automatic read_mdr(output logic [15:0] v);
    GateMDR = 1'b1; #1; v = MDRbus_out; GateMDR = 1'b0;
  endtask

  task automatic access(input logic [15:0] a, input logic rw, input logic [15:0] wd,
                        output logic [15:0] rd);
    int lat;
    load_mar(a);
    if (rw) begin
      DATABUS = wd; LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
    end
    MIO_EN = 1'b1; R_W = rw; lat = 0;
    while (R !== 1'b1 && lat < 32) begin
      tick();
      lat++;
    end
    chk($sformatf("latency %h", a), 16'(lat), (a[15:9] == 7'h7F) ? 16'd1 : 16'(MEM_LAT + 1));
    if (!rw) begin
      LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
    end
    MIO_EN = 1'b0; R_W = 1'b0; tick();
    read_mdr(rd);
  endtask

  task automatic add(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] e);
    vt[nv] = '{op: op, addr: a, data: d, exp: e};
    nv++;
  endtask

  task automatic rand_op();
    int op;
    logic [15:0] a, d, rd;
    op = $urandom_range(0, 8);
    a = 16'h3000 + 16'($urandom_range(0, 15));
    d = 16'($urandom);
    case (op)
      0: begin access(a, 1'b1, d, rd); ref_mem[a[7:0]] = d; end
      1: begin access(a, 1'b0, 16'h0, rd); chk($sformatf("mem read %h", a), rd, ref_mem[a[7:0]]); end
      2: begin
        I_char = d[7:0]; LD_char = 1'b1; tick(); LD_char = 1'b0;
        if (kb_q.size() < KB_DEPTH) kb_q.push_back(d[7:0]);
        else kb_ovr_m = 1'b1;
      end
      3: begin
        access(16'hFE02, 1'b0, 16'h0, rd);
        if (kb_q.size() > 0) chk("kbdr", rd, {8'h00, kb_q.pop_front()});
        else chk("kbdr empty", rd, 16'h0000);
      end
      4: begin
        access(16'hFE00, 1'b0, 16'h0, rd);
        chk("kbsr", rd, {kb_q.size() != 0, kb_ie_m, kb_ovr_m, 13'b0});
      end
      5: begin access(16'hFE00, 1'b1, d, rd); kb_ie_m = d[14]; kb_ovr_m = 1'b0; end
      6: begin
        access(16'hFE06, 1'b1, d, rd);
        if (dsp_q.size() < DSP_DEPTH) dsp_q.push_back(d);
      end
      7: begin
        if (d[0]) begin
          access(16'hFE04, 1'b1, d, rd); dsp_ie_m = d[14];
        end else begin
          access(16'hFE04, 1'b0, 16'h0, rd);
          chk("dsr", rd, {dsp_q.size() < DSP_DEPTH, dsp_ie_m, 14'b0});
        end
      end
      default: begin
        DDR_RDY = 1'b1;
        repeat ($urandom_range(1, 6)) tick();
        DDR_RDY = 1'b0;
        chk1("wr_ddr after drain", WR_DDR, dsp_q.size() != 0);
      end
    endcase
    chk1("kb_int", KB_INT, (kb_q.size() != 0) && kb_ie_m);
    chk1("ds_int", DS_INT, (dsp_q.size() < DSP_DEPTH) && dsp_ie_m);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic seen;

    add(OP_CHAR, 16'h0, 16'h0041, 16'h0);
    add(OP_CHAR, 16'h0, 16'h0042, 16'h0);
    add(OP_RD, 16'hFE00, 16'h0, 16'h8000);
    add(OP_RD, 16'hFE02, 16'h0, 16'h0041);
    add(OP_RD, 16'hFE02, 16'h0, 16'h0042);
    add(OP_RD, 16'hFE00, 16'h0, 16'h0000);
    add(OP_RD, 16'hFE02, 16'h0, 16'h0000);
    for (int i = 0; i < 5; i++) add(OP_CHAR, 16'h0, 16'h0031 + 16'(i), 16'h0);
    add(OP_RD, 16'hFE00, 16'h0, 16'hA000);
    add(OP_INT, 16'h0, 16'h0, 16'h0000);
    add(OP_WR, 16'hFE00, 16'h4000, 16'h0);
    add(OP_RD, 16'hFE00, 16'h0, 16'hC000);
    add(OP_INT, 16'h0, 16'h0, 16'h0004);
    add(OP_RD, 16'hFE10, 16'h0, 16'h0000);
    add(OP_WR, 16'hFE10, 16'hFFFF, 16'h0);
    add(OP_RD, 16'hFE00, 16'h0, 16'hC000);
    add(OP_RD, 16'hFE02, 16'h0, 16'h0031);
    add(OP_RD, 16'hFE04, 16'h0, 16'h8000);
    add(OP_WR, 16'hFE04, 16'h4000, 16'h0);
    add(OP_INT, 16'h0, 16'h0, 16'h0006);
    for (int i = 0; i < 5; i++) add(OP_WR, 16'hFE06, 16'h0061, 16'h0);
    add(OP_RD, 16'hFE04, 16'h0, 16'h4000);
    add(OP_INT, 16'h0, 16'h0, 16'h0005);

    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    init_ref();
    chk1("reset R", R, 1'b0);
    chk1("reset mem_en", mem_en, 1'b0);
    chk1("reset KB_INT", KB_INT, 1'b0);
    chk1("reset DS_INT", DS_INT, 1'b0);
    chk1("reset WR_DDR", WR_DDR, 1'b0);
    chk("reset DDR", DDR, 16'h0000);
    chk("reset mem_addr", mem_addr, 16'h0000);
    chk("reset mem_wdata", mem_wdata, 16'h0000);
    read_mdr(v);
    chk("reset MDR", v, 16'h0000);

    // Memory read cycle by cycle: strobe in cycle 0 only, R in cycle MEM_LAT+1.
    load_mar(16'h3000);
    MIO_EN = 1'b1; R_W = 1'b0; #1;
    chk1("t1 mem_en c0", mem_en, 1'b1);
    chk1("t1 mem_we c0", mem_we, 1'b0);
    chk("t1 mem_addr", mem_addr, 16'h3000);
    tick();
    chk1("t1 mem_en c1", mem_en, 1'b0);
    chk1("t1 R c1", R, 1'b0);
    tick();
    chk1("t1 R c2", R, 1'b0);
    tick();
    chk1("t1 R c3", R, 1'b1);
    LD_MDR = 1'b1; tick(); LD_MDR = 1'b0;
    MIO_EN = 1'b0; tick();
    read_mdr(v);
    chk("t1 MDR", v, 16'h1234);

    for (int i = 0; i < nv; i++) begin
      case (vt[i].op)
        OP_CHAR: begin I_char = vt[i].data[7:0]; LD_char = 1'b1; tick(); LD_char = 1'b0; end
        OP_RD: begin
          access(vt[i].addr, 1'b0, 16'h0, v);
          chk($sformatf("vec%0d read %h", i, vt[i].addr), v, vt[i].exp);
        end
        OP_WR: access(vt[i].addr, 1'b1, vt[i].data, v);
        default: chk($sformatf("vec%0d ints", i), {13'b0, KB_INT, DS_INT, WR_DDR}, vt[i].exp);
      endcase
    end

    // Full display FIFO drains exactly four beats.
    DDR_RDY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk1($sformatf("t4 WR_DDR beat%0d", i), WR_DDR, 1'b1);
      chk($sformatf("t4 DDR beat%0d", i), DDR, 16'h0061);
      tick();
    end
    chk1("t4 WR_DDR drained", WR_DDR, 1'b0);
    DDR_RDY = 1'b0;
    chk1("t4 DS_INT", DS_INT, 1'b1);

    // Abandoned memory read leaves MDR alone and the next access works.
    access(16'h3001, 1'b0, 16'h0, v);
    chk("t5 first read", v, ref_mem[1]);
    load_mar(16'h3002);
    MIO_EN = 1'b1; R_W = 1'b0;
    tick(); tick();
    MIO_EN = 1'b0;
    seen = 1'b0;
    repeat (6) begin tick(); seen |= R; end
    chk1("t5 R never", seen, 1'b0);
    read_mdr(v);
    chk("t5 MDR held", v, ref_mem[1]);
    access(16'h3002, 1'b0, 16'h0, v);
    chk("t5 retry read", v, ref_mem[2]);

    // Reset while in MWAIT with both FIFOs holding data.
    I_char = 8'h55; LD_char = 1'b1; tick(); LD_char = 1'b0;
    access(16'hFE06, 1'b1, 16'h0077, v);
    access(16'hFE04, 1'b1, 16'h4000, v);
    chk1("t6 pre WR_DDR", WR_DDR, 1'b1);
    load_mar(16'h3003);
    MIO_EN = 1'b1; R_W = 1'b0;
    tick();
    reset = 1'b1; MIO_EN = 1'b0;
    tick();
    reset = 1'b0;
    init_ref();
    chk1("t6 R", R, 1'b0);
    chk1("t6 mem_en", mem_en, 1'b0);
    chk1("t6 KB_INT", KB_INT, 1'b0);
    chk1("t6 DS_INT", DS_INT, 1'b0);
    chk1("t6 WR_DDR", WR_DDR, 1'b0);
    chk("t6 DDR", DDR, 16'h0000);
    chk("t6 mem_addr", mem_addr, 16'h0000);
    read_mdr(v);
    chk("t6 MDR", v, 16'h0000);
    seen = 1'b0;
    repeat (4) begin tick(); seen |= R; end
    chk1("t6 no stale R", seen, 1'b0);
    access(16'hFE00, 1'b0, 16'h0, v);
    chk("t6 KBSR", v, 16'h0000);

    mon_en = 1'b1;
    repeat (300) rand_op();
    DDR_RDY = 1'b1;
    repeat (DSP_DEPTH + 1) tick();
    DDR_RDY = 1'b0;
    chk1("final drain", WR_DDR, 1'b0);
    chk("final model empty", 16'(dsp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
